// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller feeding the instruction FIFO
//
// Holds the fetch PC, issues one dual-word request at a time on the
// SRAM-like instruction bus and pushes each returned pair into the FIFO.
// Redirects flush the FIFO and drop any stale in-flight response.
//
// Optional feature macro: IF_PERF_CNT_EN (adds fetch/discard counters).
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   redirect_en, redirect_pc    redirect request and word-aligned target
//   inst_req, inst_addr         bus request valid / address (= pc)
//   inst_addr_ok, inst_data_ok  bus request accepted / response valid
//   inst_rdata1, inst_rdata2    words at request address and address + 4
//   fifo_full                   FIFO cannot take two more entries
//   fifo_rst                    FIFO pointer reset (redirect flush)
//   write_en1/2                 push word 1 / word 2
//   write_address1/2            PCs of the pushed words
//   write_data1/2               pushed instruction words
//   perf_fetch_cnt              words pushed (IF_PERF_CNT_EN only)
//   perf_discard_cnt            responses dropped (IF_PERF_CNT_EN only)

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata1,
  input  logic [31:0] inst_rdata2,
  input  logic        fifo_full,
  output logic        fifo_rst,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt,
`endif
  output logic        write_en1,
  output logic        write_en2,
  output logic [31:0] write_address1,
  output logic [31:0] write_address2,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;

  logic        resp_take;
  logic        resp_drop;
  logic [31:0] next_seq_pc;

  // An odd-word start only yields one usable word, so the next fetch
  // begins at the following word rather than skipping a pair.
  assign next_seq_pc = req_pc + (req_pc[2] ? 32'd4 : 32'd8);

  always_comb begin
    inst_req       = 1'b0;
    fifo_rst       = 1'b0;
    resp_take      = 1'b0;
    resp_drop      = 1'b0;
    write_en1      = 1'b0;
    write_en2      = 1'b0;
    write_address1 = 32'd0;
    write_address2 = 32'd0;
    write_data1    = 32'd0;
    write_data2    = 32'd0;
    inst_addr      = pc;
    if (resetn) begin
      fifo_rst  = redirect_en;
      inst_req  = (state == S_REQ) && !fifo_full && !redirect_en;
      // fifo_full is deliberately ignored here: the FIFO threshold keeps
      // room for the one response that can be outstanding.
      resp_take = (state == S_WAIT) && inst_data_ok && !redirect_en;
      resp_drop = inst_data_ok &&
                  ((state == S_DISCARD) || ((state == S_WAIT) && redirect_en));
      write_en1      = resp_take;
      write_en2      = resp_take && !req_pc[2];
      write_address1 = req_pc;
      write_address2 = req_pc + 32'd4;
      write_data1    = inst_rdata1;
      write_data2    = inst_rdata2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc     <= RESET_PC;
      req_pc <= 32'd0;
      state  <= S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_en) begin
            pc <= redirect_pc;
          end else if (inst_req && inst_addr_ok) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_en) begin
            pc <= redirect_pc;
            // Without the response in hand we must still swallow it later.
            state <= inst_data_ok ? S_REQ : S_DISCARD;
          end else if (inst_data_ok) begin
            pc    <= next_seq_pc;
            state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (redirect_en) begin
            pc <= redirect_pc;
          end
          // The stale response closes the outstanding slot; pc already
          // holds the most recent redirect target.
          if (inst_data_ok) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_fetch_cnt   <= 32'd0;
      perf_discard_cnt <= 32'd0;
    end else begin
      perf_fetch_cnt   <= perf_fetch_cnt + {31'd0, write_en1} + {31'd0, write_en2};
      perf_discard_cnt <= perf_discard_cnt + {31'd0, resp_drop};
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard testbench for if_fetch_ctrl

module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata1 = 32'd0;
  logic [31:0] inst_rdata2 = 32'd0;
  logic        fifo_full = 1'b0;
  logic        fifo_rst;
  logic        write_en1, write_en2;
  logic [31:0] write_address1, write_address2, write_data1, write_data2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_discard_cnt;
`endif

  if_fetch_ctrl dut (
    .clk(clk), .resetn(resetn),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata1(inst_rdata1), .inst_rdata2(inst_rdata2),
    .fifo_full(fifo_full), .fifo_rst(fifo_rst),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_discard_cnt(perf_discard_cnt),
`endif
    .write_en1(write_en1), .write_en2(write_en2),
    .write_address1(write_address1), .write_address2(write_address2),
    .write_data1(write_data1), .write_data2(write_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] d1;
    logic [31:0] a2;
    logic [31:0] d2;
    logic        en2;
  } wr_t;

  wr_t         sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_fetch = 0;
  logic [31:0] exp_discard = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every push must match the oldest expected pair.
  always @(negedge clk) begin
    if (write_en1 || write_en2) begin
      wr_t e;
      check("we2_without_we1", {31'd0, write_en2 & ~write_en1}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", write_address1, 32'hDEAD_BEEF);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr1", write_address1, e.a1);
        check("wr_data1", write_data1, e.d1);
        check("wr_en2", {31'd0, write_en2}, {31'd0, e.en2});
        if (e.en2) begin
          check("wr_addr2", write_address2, e.a2);
          check("wr_data2", write_data2, e.d2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request at address a and accept it.
  task automatic accept(input logic [31:0] a);
    int n = 0;
    while (!inst_req && n < 20) begin
      step();
      n++;
    end
    check("req_seen", {31'd0, inst_req}, 32'd1);
    check("req_addr", inst_addr, a);
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    check("wait_no_req", {31'd0, inst_req}, 32'd0);
  endtask

  // Full transaction: data_ok two cycles after addr_ok.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d1,
                       input logic [31:0] d2, input bit full_in_wait);
    wr_t e;
    accept(a);
    if (full_in_wait) fifo_full = 1'b1;
    step();
    e.a1 = a; e.d1 = d1; e.a2 = a + 32'd4; e.d2 = d2; e.en2 = !a[2];
    sb_q.push_back(e);
    exp_fetch += a[2] ? 32'd1 : 32'd2;
    inst_data_ok = 1'b1;
    inst_rdata1 = d1;
    inst_rdata2 = d2;
    step();
    inst_data_ok = 1'b0;
    fifo_full = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    step();
    check("rst_req", {31'd0, inst_req}, 32'd0);
    check("rst_we1", {31'd0, write_en1}, 32'd0);
    check("rst_addr", inst_addr, 32'hBFC0_0000);
    resetn = 1'b1;
    #1;
    check("first_req", {31'd0, inst_req}, 32'd1);

    // Reset release: full pair
    fetch(32'hBFC0_0000, 32'h1111_1111, 32'h2222_2222, 1'b0);
    check("seq_next_addr", inst_addr, 32'hBFC0_0008);

    // Redirect in REQ to an odd word
    redirect_en = 1'b1;
    redirect_pc = 32'hBFC0_0014;
    #1;
    check("redir_req_fifo_rst", {31'd0, fifo_rst}, 32'd1);
    check("redir_req_noreq", {31'd0, inst_req}, 32'd0);
    step();
    redirect_en = 1'b0;
    fetch(32'hBFC0_0014, 32'h3333_3333, 32'h4444_4444, 1'b0);
    check("odd_next_addr", inst_addr, 32'hBFC0_0018);

    // Redirect while waiting -> discard the later response
    accept(32'hBFC0_0018);
    redirect_en = 1'b1;
    redirect_pc = 32'h8000_0100;
    #1;
    check("redir_wait_fifo_rst", {31'd0, fifo_rst}, 32'd1);
    step();
    redirect_en = 1'b0;
    check("discard_noreq", {31'd0, inst_req}, 32'd0);
    step();
    inst_data_ok = 1'b1;
    inst_rdata1 = 32'h5555_5555;
    inst_rdata2 = 32'h6666_6666;
    #1;
    check("discard_no_we1", {31'd0, write_en1}, 32'd0);
    exp_discard++;
    step();
    inst_data_ok = 1'b0;
    check("after_discard_addr", inst_addr, 32'h8000_0100);

    // Redirect coincident with data_ok
    accept(32'h8000_0100);
    step();
    inst_data_ok = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1;
    check("coinc_no_we1", {31'd0, write_en1}, 32'd0);
    check("coinc_no_we2", {31'd0, write_en2}, 32'd0);
    check("coinc_fifo_rst", {31'd0, fifo_rst}, 32'd1);
    exp_discard++;
    step();
    inst_data_ok = 1'b0;
    redirect_en = 1'b0;
    #1;
    check("coinc_req_now", {31'd0, inst_req}, 32'd1);
    check("coinc_addr", inst_addr, 32'h8000_0200);

    // fifo_full holds the PC in REQ, not the outstanding write
    fifo_full = 1'b1;
    #1;
    check("full_noreq", {31'd0, inst_req}, 32'd0);
    step();
    step();
    check("full_pc_held", inst_addr, 32'h8000_0200);
    check("full_noreq2", {31'd0, inst_req}, 32'd0);
    fifo_full = 1'b0;
    fetch(32'h8000_0200, 32'h7777_7777, 32'h8888_8888, 1'b1);
    check("full_next_addr", inst_addr, 32'h8000_0208);

    // Address wrap-around
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_en = 1'b0;
    fetch(32'hFFFF_FFF8, 32'h9999_9999, 32'hAAAA_AAAA, 1'b0);
    check("wrap_next_addr", inst_addr, 32'h0000_0000);
    fetch(32'h0000_0000, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 1'b0);

    // Enter DISCARD, then reset mid-operation
    accept(32'h0000_0008);
    redirect_en = 1'b1;
    redirect_pc = 32'h1234_0000;
    step();
    redirect_en = 1'b0;
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, exp_fetch);
    check("perf_discard", perf_discard_cnt, exp_discard);
`endif
    resetn = 1'b0;
    redirect_en = 1'b1;
    inst_data_ok = 1'b1;
    #1;
    check("rst_mid_fifo_rst", {31'd0, fifo_rst}, 32'd0);
    check("rst_mid_we1", {31'd0, write_en1}, 32'd0);
    check("rst_mid_req", {31'd0, inst_req}, 32'd0);
    step();
    check("rst_mid_pc", inst_addr, 32'hBFC0_0000);
`ifdef IF_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_discard", perf_discard_cnt, 32'd0);
`endif
    resetn = 1'b1;
    redirect_en = 1'b0;
    inst_data_ok = 1'b0;
    #1;
    check("rst_mid_req_after", {31'd0, inst_req}, 32'd1);
    check("rst_mid_addr_after", inst_addr, 32'hBFC0_0000);
    step();
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
